// File: rtl/instr_queue_pkg.sv
// Shared constants for the fetch-to-decode instruction queue.
// Default geometry and the NOP encoding presented while the queue is empty.
package instr_queue_pkg;

    localparam int DEFAULT_DEPTH   = 4;
    localparam int DEFAULT_ADDR_W  = 32;
    localparam int DEFAULT_INSTR_W = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_DEQ  = 2'b01,
        OP_ENQ  = 2'b10,
        OP_BOTH = 2'b11
    } queue_op_e;

endpackage

// File: rtl/instr_queue_mem.sv
// DEPTH-entry register file for the instruction queue.
// One synchronous write port and one asynchronous read port.
module instr_queue_mem #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 64,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array is reset here so a reset mid-write leaves no partial
    // entry behind; this costs a reset net per flop instead of a RAM macro.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_queue.sv
// Circular FIFO of {pc, instr} pairs between fetch and decode.
// Flush has priority; full and empty never bypass.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int INSTR_W = DEFAULT_INSTR_W,
    parameter int PTR_W   = $clog2(DEPTH),
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enq_valid_i,
    input  logic [ADDR_W-1:0]  enq_pc_i,
    input  logic [INSTR_W-1:0] enq_instr_i,
    output logic               instr_queue_ready_o,
    output logic               deq_valid_o,
    output logic [ADDR_W-1:0]  deq_pc_o,
    output logic [INSTR_W-1:0] deq_instr_o,
    input  logic               deq_ready_i,
    input  logic               flush_i,
    output logic [CNT_W-1:0]   count_o
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          count;
    logic                      enq_fire;
    logic                      deq_fire;
    logic [ADDR_W+INSTR_W-1:0] head_entry;
    queue_op_e                 op;

    assign instr_queue_ready_o = (count != FULL_CNT);
    assign deq_valid_o         = (count != '0);
    assign count_o             = count;

    assign enq_fire = enq_valid_i & instr_queue_ready_o & ~flush_i;
    assign deq_fire = deq_valid_o & deq_ready_i & ~flush_i;
    assign op       = queue_op_e'({enq_fire, deq_fire});

    instr_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INSTR_W),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en   (enq_fire),
        .wr_addr (wr_ptr),
        .wr_data ({enq_pc_i, enq_instr_i}),
        .rd_addr (rd_ptr),
        .rd_data (head_entry)
    );

    // NOTE: non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + PTR_ONE;
            if (deq_fire) rd_ptr <= rd_ptr + PTR_ONE;
            case (op)
                OP_ENQ:  count <= count + CNT_ONE;
                OP_DEQ:  count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: defaults first so no path through this block infers a latch.
    always_comb begin
        deq_pc_o    = '0;
        deq_instr_o = INSTR_W'(NOP_INSTR);
        if (deq_valid_o) begin
            deq_pc_o    = head_entry[ADDR_W+INSTR_W-1:INSTR_W];
            deq_instr_o = head_entry[INSTR_W-1:0];
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue: fill, full-bypass refusal,
// streaming across pointer wrap, flush priority and asynchronous reset.
module tb_instr_queue;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        enq_valid_i = 1'b0;
    logic [31:0] enq_pc_i = '0;
    logic [31:0] enq_instr_i = '0;
    logic        instr_queue_ready_o;
    logic        deq_valid_o;
    logic [31:0] deq_pc_o;
    logic [31:0] deq_instr_o;
    logic        deq_ready_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [2:0]  count_o;

    int checks = 0;
    int errors = 0;

    instr_queue dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .enq_valid_i         (enq_valid_i),
        .enq_pc_i            (enq_pc_i),
        .enq_instr_i         (enq_instr_i),
        .instr_queue_ready_o (instr_queue_ready_o),
        .deq_valid_o         (deq_valid_o),
        .deq_pc_o            (deq_pc_o),
        .deq_instr_o         (deq_instr_o),
        .deq_ready_i         (deq_ready_i),
        .flush_i             (flush_i),
        .count_o             (count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic ev, input logic [31:0] pc, input logic dr, input logic fl);
        enq_valid_i = ev;
        enq_pc_i    = pc;
        enq_instr_i = instr_of(pc);
        deq_ready_i = dr;
        flush_i     = fl;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, 64'(deq_valid_o), 64'd1);
        check({tag, "_pc"}, 64'(deq_pc_o), 64'(pc));
        check({tag, "_instr"}, 64'(deq_instr_o), 64'(instr_of(pc)));
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_count"}, 64'(count_o), 64'd0);
        check({tag, "_valid"}, 64'(deq_valid_o), 64'd0);
        check({tag, "_ready"}, 64'(instr_queue_ready_o), 64'd1);
        check({tag, "_pc"}, 64'(deq_pc_o), 64'd0);
        check({tag, "_instr"}, 64'(deq_instr_o), 64'h13);
    endtask

    initial begin
        // Reset then idle
        #1 rst_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
        tick();
        check_empty("reset");

        // Fill with deq_ready low; 5th enqueue must be ignored
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        check("fill_count", 64'(count_o), 64'd4);
        check("fill_ready", 64'(instr_queue_ready_o), 64'd0);
        drive(1'b1, 32'h110, 1'b0, 1'b0);
        tick();
        check("fifth_ignored_count", 64'(count_o), 64'd4);
        check_head("fifth_ignored_head", 32'h100);

        // Full + enq + deq in one cycle: only the dequeue fires
        drive(1'b1, 32'h110, 1'b1, 1'b0);
        tick();
        check("full_bypass_count", 64'(count_o), 64'd3);
        check_head("full_bypass_head", 32'h104);
        drive(1'b1, 32'h110, 1'b0, 1'b0);
        tick();
        check("held_enq_count", 64'(count_o), 64'd4);

        // Drain and verify order
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            check_head($sformatf("drain%0d", i), 32'h104 + 32'(4 * i));
            tick();
        end
        check_empty("drained");
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        check("no_underflow_count", 64'(count_o), 64'd0);

        // Stream 10 cycles from count=2, crossing the pointer wrap
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        check("stream_pre_count", 64'(count_o), 64'd2);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h208 + 32'(4 * k), 1'b1, 1'b0);
            check_head($sformatf("stream%0d", k), 32'h200 + 32'(4 * k));
            tick();
            check($sformatf("stream%0d_count", k), 64'(count_o), 64'd2);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            check_head($sformatf("stream_tail%0d", i), 32'h228 + 32'(4 * i));
            tick();
        end
        check("stream_post_count", 64'(count_o), 64'd0);

        // Flush beats simultaneous enq and deq
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        check("preflush_count", 64'(count_o), 64'd3);
        drive(1'b1, 32'h40C, 1'b1, 1'b1);
        tick();
        check_empty("flush");
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        #1;
        check("no_bypass_valid", 64'(deq_valid_o), 64'd0);
        tick();
        check("post_flush_count", 64'(count_o), 64'd1);
        check_head("post_flush_head", 32'h300);

        // Asynchronous reset mid-cycle with count=2
        drive(1'b1, 32'h304, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("prereset_count", 64'(count_o), 64'd2);
        #2 rst_i = 1'b1;
        #1;
        check_empty("async_reset");
        tick();
        rst_i = 1'b0;
        tick();
        check_empty("after_reset");

        // Queue still works after reset
        drive(1'b1, 32'h500, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check_head("after_reset_head", 32'h500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Instruction queue between the fetch stage (I-cache output) and decode.
- It is the block that produces `instr_queue_ready_o`, which the pipeline control unit consumes to raise its stall.
- It consumes that unit's `flush_o` and stall to discard or hold buffered instructions.
- Circular FIFO of {pc, instr} pairs with a valid/ready handshake on both sides.

Parameters:
- DEPTH, 4, number of entries; must be a power of two, minimum 2.
- ADDR_W, 32, PC width.
- INSTR_W, 32, instruction width.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- enq_valid_i  input  1  fetch presents a valid instruction.
- enq_pc_i  input  ADDR_W  PC of the fetched instruction.
- enq_instr_i  input  INSTR_W  fetched instruction word.
- instr_queue_ready_o  output  1  queue can accept an enqueue this cycle.
- deq_valid_o  output  1  head entry is valid.
- deq_pc_o  output  ADDR_W  PC of the head entry.
- deq_instr_o  output  INSTR_W  instruction of the head entry.
- deq_ready_i  input  1  decode accepts the head entry this cycle; driven low by decode while stalled.
- flush_i  input  1  pipeline flush (branch miss or exception).
- count_o  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Internal state:
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - count register, $clog2(DEPTH)+1 bits.
  - Storage array of DEPTH x (ADDR_W+INSTR_W).
- Reset (asynchronous on rst_i=1):
  - Pointers=0, count=0, all storage=0.
  - count_o=0, deq_valid_o=0, instr_queue_ready_o=1.
  - deq_pc_o=0, deq_instr_o=NOP (32'h00000013).
  - Reset asserted mid-operation discards all contents immediately; no partial writes survive.
- Derived outputs, combinational from registered state only (no path from enq_* or deq_ready_i):
  - instr_queue_ready_o = (count != DEPTH).
  - deq_valid_o = (count != 0).
  - count_o = count.
- Head outputs:
  - When count != 0: deq_pc_o and deq_instr_o = storage[rd_ptr] (asynchronous read).
  - When empty: deq_pc_o=0 and deq_instr_o=NOP.
- Handshake:
  - enq_fire = enq_valid_i & instr_queue_ready_o & ~flush_i.
  - deq_fire = deq_valid_o & deq_ready_i & ~flush_i.
- Enqueue: on enq_fire, storage[wr_ptr] <= {enq_pc_i, enq_instr_i} and wr_ptr increments.
- Dequeue: on deq_fire, rd_ptr increments.
- Count update:
  - +1 on enq_fire only.
  - -1 on deq_fire only.
  - Unchanged when both or neither fire.
- Latency: minimum one cycle from enqueue to visibility at the head. There is no combinational bypass from enq_* to deq_*.
- Full: enq_valid_i is ignored while instr_queue_ready_o=0, even if a dequeue fires in the same cycle (no full-bypass). Fetch must hold its data.
- Empty: deq_ready_i has no effect; count never underflows.
- Simultaneous enq+deq with 0<count<DEPTH: both pointers advance and count is unchanged.
- Flush:
  - flush_i=1 at an edge sets wr_ptr=rd_ptr=0 and count=0.
  - Any enq/deq in that cycle is discarded.
  - Storage contents are not cleared (they are don't-care).
  - The next cycle shows deq_valid_o=0 and instr_queue_ready_o=1.
  - flush_i takes priority over every other event.
- Wrap: when a pointer is at DEPTH-1 and increments, it returns to 0. Entry order is preserved across the wrap.

Decomposition:
- Shared parameters header holds INSTR_W, ADDR_W, NOP encoding (32'h00000013) and the default DEPTH.
- One natural sub-module: instr_queue_mem.
  - DEPTH-entry register file, 1 synchronous write port, 1 asynchronous read port, indexed by pointer.
  - Pointer/count/handshake logic stays in instr_queue.

Test Plan:
- Reset then idle -> instr_queue_ready_o=1, deq_valid_o=0, count_o=0, deq_instr_o=32'h00000013.
- Enqueue pc 0x100..0x10C (4 instrs) with deq_ready_i=0 -> count_o=4, instr_queue_ready_o=0; a 5th enq_valid_i is ignored; after draining, the dequeue order is 0x100, 0x104, 0x108, 0x10C.
- Queue full and, same cycle, enq_valid_i=1 with deq_ready_i=1 -> only the dequeue fires and count_o goes to 3; the held enqueue is accepted next cycle, giving count_o=4.
- Continuous enq+deq for 10 cycles (pc 0x200 step 4) from count=2 -> count_o stays 2; pointer wrap preserves order and no entry is lost or duplicated.
- count=3, then flush_i=1 together with enq_valid_i=1 and deq_ready_i=1 -> next cycle count_o=0, deq_valid_o=0, instr_queue_ready_o=1; the following enqueue of pc 0x300 appears at the head one cycle later.
- rst_i pulsed asynchronously mid-cycle with count=2 -> outputs return to reset values immediately, without waiting for a clock edge.
